// File: rtl/vec_seq5.sv
// vec_seq5: exhaustive five-input stimulus sequencer with response capture.
// Drives all 32 combinations of {a,b,c,d,e} (a = MSB) for HOLD cycles each,
// samples f_in at the last edge of every hold window and records the
// truth table in resp, plus a count of ones in ones_cnt.
// Optional build macro VEC_SEQ5_SELFCHECK_EN adds an internal reference
// for F = (A+B)(C+D)E and counts mismatches in err_cnt; otherwise err_cnt
// is tied to zero. The port list is the same in both builds.
module vec_seq5 #(
    parameter int unsigned HOLD = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        busy,
    output logic        done,
    output logic [5:0]  ones_cnt,
    output logic [31:0] resp,
    output logic [5:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [4:0] IDX_LAST  = 5'd31;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic [7:0]  hold_cnt;
    logic [4:0]  vec;
    logic        accept;
    logic        sample;
    logic [31:0] resp_q;
    logic [5:0]  ones_q;

    assign accept = (state == IDLE) && start;

    // State register; reset returns to IDLE and cancels any sweep in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state outputs; the vector is only driven in DRIVE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        vec       = '0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy   = 1'b1;
                vec    = idx;
                sample = (hold_cnt == HOLD_LAST);
                if (sample && (idx == IDX_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign {a, b, c, d, e} = vec;

    // Vector index, hold timer and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            hold_cnt <= '0;
            resp_q   <= '0;
            ones_q   <= '0;
        end else if (accept) begin
            idx      <= '0;
            hold_cnt <= '0;
            resp_q   <= '0;
            ones_q   <= '0;
        end else if (state == DRIVE) begin
            if (sample) begin
                resp_q[idx] <= f_in;
                ones_q      <= ones_q + {5'd0, f_in};
                hold_cnt    <= '0;
                if (idx != IDX_LAST) begin
                    idx <= idx + 5'd1;
                end
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign resp     = resp_q;
    assign ones_cnt = ones_q;

`ifdef VEC_SEQ5_SELFCHECK_EN
    logic       exp_f;
    logic [5:0] err_q;

    // Reference model of the stage under drive, evaluated on the driven vector.
    always_comb begin
        exp_f = (vec[4] | vec[3]) & (vec[2] | vec[1]) & vec[0];
    end

    // Mismatch counter, cleared together with the response on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (accept) begin
            err_q <= '0;
        end else if (sample && (f_in != exp_f)) begin
            err_q <= err_q + 6'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/vec_seq5.md
# vec_seq5

Exhaustive five-input stimulus sequencer and response capture for the single-output combinational stage F = (A+B)(C+D)E. On `start` it drives all 32 input combinations onto `a..e`, holds each for `HOLD` cycles and samples the returned `f_in` at the end of each hold. It accumulates a 32-bit response word and a count of ones, so the whole truth table is captured in hardware with no testbench-side monitoring.

## Interface
- `HOLD`, default 10: cycles each vector is held. Legal range 1..255.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `start  in  1`: begin a sweep; honoured only in IDLE.
- `f_in  in  1`: output of the combinational stage under drive.
- `a, b, c, d, e  out  1 each`: driven vector; `{a,b,c,d,e}` = 5-bit index, `a` is MSB.
- `busy  out  1`: high while a sweep is in progress.
- `done  out  1`: one-cycle pulse after the last sample.
- `ones_cnt  out  6`: number of vectors for which `f_in` sampled 1.
- `resp  out  32`: `resp[i]` = `f_in` sampled while index i was driven.
- `err_cnt  out  6`: self-check mismatch count; see Configuration.

## Operation
- States: IDLE, DRIVE, DONE.
- **Reset values:** state IDLE; `a..e`=0; `busy`=0; `done`=0; `ones_cnt`=0; `resp`=0; `err_cnt`=0.
- **IDLE:** `a..e`=0 and `busy`=0.
  - `start`=1 moves to DRIVE.
  - On that transition: `idx`=0, `hold_cnt`=0, and `resp`, `ones_cnt`, `err_cnt` cleared.
- **DRIVE:** `busy`=1; `{a,b,c,d,e}`=`idx`; `hold_cnt` increments every cycle.
  - When `hold_cnt`==HOLD-1, on that edge:
    - `resp[idx]` ← `f_in`.
    - `ones_cnt` += `f_in`.
  - If `idx`==31, go to DONE. Otherwise `idx`+1 and `hold_cnt` ← 0.
- **DONE:** lasts exactly one cycle.
  - `done`=1, `busy`=0, `a..e`=0.
  - Next state is IDLE unconditionally.
- `start` is ignored in DRIVE and DONE; no restart or queueing.
- `resp`, `ones_cnt` and `err_cnt` hold their final values until the next accepted `start` or `rst`.
- Width rules:
  - `ones_cnt` and `err_cnt` max 32, so 6 bits is sufficient and there is no saturation logic.
  - `hold_cnt` is 8 bits.
  - `idx` is 5 bits and does not wrap during a sweep.

## Timing
- `start` sampled high at edge T:
  - `busy` and vector 0 appear after T.
  - Vector k is driven for cycles T+1+k·HOLD .. T+(k+1)·HOLD.
- `f_in` is sampled at the last edge of each vector's window. The driven stage is combinational and must settle within one cycle.
- `done` is high in the single cycle following edge T+32·HOLD.
- Total `busy` time is 32·HOLD cycles.
- HOLD=1: a new vector every cycle, sampled every edge.
- `rst` asserted mid-sweep: on the next edge all outputs take their reset values and the state is IDLE. No `done` pulse is produced.
- `rst` and `start` both high: `rst` wins.

## Configuration
- Macro `VEC_SEQ5_SELFCHECK_EN`.
- **Defined:**
  - An internal reference computes `exp` = (a|b)&(c|d)&e from the driven vector.
  - At each sample edge, if `f_in` != `exp` then `err_cnt` += 1.
- **Undefined:**
  - No reference logic is built.
  - `err_cnt` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- **Correct DUT, HOLD=10:** `start` pulse → `busy` for 320 cycles, one `done` pulse, `resp`=32'hA8A8A800, `ones_cnt`=9, `err_cnt`=0.
- **HOLD=1 timing:** `start` at edge T → vector k visible in cycle T+1+k; `done` in cycle T+33; same `resp`/`ones_cnt` as above.
- **Stuck-at-0 DUT (`f_in`=0):** `resp`=0, `ones_cnt`=0. With `VEC_SEQ5_SELFCHECK_EN`: `err_cnt`=9. Without it: `err_cnt`=0.
- **`start` re-pulsed at vector 5 mid-sweep:** ignored; sweep completes normally with a single `done`.
- **`rst` at vector 12:** next cycle `busy`=0, `a..e`=0, `resp`=0, no `done`. A following `start` produces a full, correct sweep.
- **Back-to-back:** `start` held high continuously → ignored during DONE; a new sweep begins from IDLE one cycle after `done`. `resp` is cleared at that restart.
